// File: rtl/audio_pkg.sv
// Shared audio constants: sample width, I2S frame layout and default clock
// divider exponents (also used by the note generator's divider math).
package audio_pkg;

  localparam int SAMPLE_W         = 16;
  localparam int SLOTS_PER_FRAME  = 64;
  localparam int SLOT_IDX_W       = $clog2(SLOTS_PER_FRAME);
  localparam int LEFT_FIRST_SLOT  = 1;
  localparam int RIGHT_FIRST_SLOT = 33;

  localparam int MCLK_DIV_LOG2_DFLT = 2;
  localparam int SCK_DIV_LOG2_DFLT  = 5;

  // What a given SCK slot of the frame carries.
  typedef enum logic [1:0] {
    SLOT_DELAY = 2'd0,  // one-SCK I2S delay slot ahead of each word
    SLOT_LEFT  = 2'd1,
    SLOT_RIGHT = 2'd2,
    SLOT_PAD   = 2'd3   // unused tail of a half-frame, driven as 0
  } slot_kind_e;

  function automatic slot_kind_e slot_kind(input logic [SLOT_IDX_W-1:0] slot,
                                           input int sample_w);
    int s;
    s = int'(slot);
    if (s >= LEFT_FIRST_SLOT && s < LEFT_FIRST_SLOT + sample_w)
      return SLOT_LEFT;
    else if (s >= RIGHT_FIRST_SLOT && s < RIGHT_FIRST_SLOT + sample_w)
      return SLOT_RIGHT;
    else if (s == LEFT_FIRST_SLOT - 1 || s == RIGHT_FIRST_SLOT - 1)
      return SLOT_DELAY;
    else
      return SLOT_PAD;
  endfunction

endpackage

// File: rtl/i2s_audio_tx.sv
// I2S transmitter: derives MCLK/SCK/LRCK from one frame counter, latches a
// stereo sample pair once per frame and shifts it out MSB first with the
// standard one-SCK delay after each LRCK change.
module i2s_audio_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W      = audio_pkg::SAMPLE_W,
  parameter int MCLK_DIV_LOG2 = MCLK_DIV_LOG2_DFLT,
  parameter int SCK_DIV_LOG2  = SCK_DIV_LOG2_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] audio_left,
  input  logic [SAMPLE_W-1:0] audio_right,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_sck,
  output logic                audio_sdin,
  output logic                sample_req
);

  localparam int FRAME_W = SCK_DIV_LOG2 + SLOT_IDX_W;
  localparam int BIT_IDX_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

  logic [FRAME_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]   hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0]   hold_r_q, hold_r_d;
  logic                  sdin_q, sdin_d;
  logic                  req_q, req_d;

  logic                  frame_wrap;
  logic                  slot_start;
  logic [SLOT_IDX_W-1:0] slot_nxt;
  int                    slot_i;
  int                    idx_l;
  int                    idx_r;
  logic                  slot_bit;

  // Edge qualifiers: last count of the frame, and last count of an SCK slot
  // (the next edge is the SCK falling edge that opens a new slot).
  assign frame_wrap = enable && (cnt_q == '1);
  assign slot_start = enable && (cnt_q[SCK_DIV_LOG2-1:0] == '1);
  assign slot_nxt   = cnt_q[FRAME_W-1:SCK_DIV_LOG2] + SLOT_IDX_W'(1);

  // Select the serial bit for the slot that starts on the next SCK fall.
  always_comb begin
    slot_bit = 1'b0;
    slot_i   = int'(slot_nxt);
    idx_l    = LEFT_FIRST_SLOT + SAMPLE_W - 1 - slot_i;
    idx_r    = RIGHT_FIRST_SLOT + SAMPLE_W - 1 - slot_i;
    unique case (slot_kind(slot_nxt, SAMPLE_W))
      SLOT_LEFT:  slot_bit = hold_l_q[BIT_IDX_W'(idx_l)];
      SLOT_RIGHT: slot_bit = hold_r_q[BIT_IDX_W'(idx_r)];
      default:    slot_bit = 1'b0;
    endcase
  end

  // Next-state: counter, per-frame sample hold, data bit and latch strobe.
  always_comb begin
    cnt_d    = '0;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    sdin_d   = sdin_q;
    req_d    = frame_wrap;
    if (enable) begin
      cnt_d = cnt_q + FRAME_W'(1);
    end
    if (frame_wrap) begin
      hold_l_d = audio_left;
      hold_r_d = audio_right;
    end
    if (!enable) begin
      sdin_d = 1'b0;
    end else if (slot_start) begin
      sdin_d = slot_bit;
    end
  end

  // State registers; the hold pair survives enable drops, only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      sdin_q   <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      sdin_q   <= sdin_d;
      req_q    <= req_d;
    end
  end

  // Clocks come straight from counter flops so they cannot glitch.
  assign audio_mclk = cnt_q[MCLK_DIV_LOG2-1];
  assign audio_sck  = cnt_q[SCK_DIV_LOG2-1];
  assign audio_lrck = cnt_q[FRAME_W-1];
  assign audio_sdin = sdin_q;
  // Strobe is registered so it never fires on the enable rising edge itself.
  assign sample_req = req_q & enable;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: directed sequence with random sample pairs,
// compared against a frame-level model of the I2S bit layout.
module tb_i2s_audio_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;
  logic        sample_req;

  int n_cmp = 0;
  int n_err = 0;

  i2s_audio_tx dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .audio_mclk  (audio_mclk),
    .audio_lrck  (audio_lrck),
    .audio_sck   (audio_sck),
    .audio_sdin  (audio_sdin),
    .sample_req  (sample_req)
  );

  always #5 clk = ~clk;

  // Expected 64-slot frame, slot 0 in bit 63: delay, 16-bit word, 15 pad, twice.
  function automatic logic [63:0] i2s_frame(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'd0, 1'b0, r, 15'd0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [4:0] outs();
    return {audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req};
  endfunction

  // Step cycles until sample_req, collecting sdin at every SCK rising edge.
  task automatic collect_until_req(input int limit, input int mid_slot, input logic [15:0] mid_l,
                                   output int ncyc, output logic [63:0] bits, output int nrise);
    logic ps;
    bits  = '0;
    nrise = 0;
    ncyc  = 0;
    ps    = audio_sck;
    for (int i = 0; i < limit; i++) begin
      step();
      ncyc++;
      if (audio_sck && !ps) begin
        if (nrise < 64) bits[63-nrise] = audio_sdin;
        if (nrise == mid_slot) audio_left = mid_l;
        nrise++;
      end
      ps = audio_sck;
      if (sample_req) break;
    end
  endtask

  int          ncyc, nrise;
  logic [63:0] bits;
  logic [63:0] exp_frame;
  logic [15:0] held_l, held_r;
  logic [15:0] new_l [9];
  logic [15:0] new_r [9];
  int          mid_at [9];
  logic [3:0]  sig, psig;
  int          hi_cnt [4];
  int          rise_cnt [4];
  int          last_rise [4];
  int          bad_int [4];
  int          period [4] = '{4, 32, 2048, 2048};
  int          exp_hi [4] = '{2048, 2048, 2048, 2};
  int          exp_rise [4] = '{1024, 128, 2, 2};
  string       names [4] = '{"mclk", "sck", "lrck", "sample_req"};
  logic [4:0]  acc;
  logic        ps;

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    audio_left = '0;
    audio_right = '0;
    repeat (3) step();
    chk("reset_outputs", 64'(outs()), 64'd0);
    rst = 1'b0;
    collect_until_req(2100, -1, '0, ncyc, bits, nrise);
    chk("first_req_after_reset", 64'(ncyc), 64'd2048);
    chk("first_frame_zero", bits, 64'd0);

    // Clock periods / duty over two full frames starting at a latch cycle.
    psig = {sample_req, audio_lrck, audio_sck, audio_mclk};
    for (int k = 0; k < 4; k++) begin
      hi_cnt[k] = 0; rise_cnt[k] = 0; last_rise[k] = -1; bad_int[k] = 0;
    end
    for (int i = 1; i <= 4096; i++) begin
      step();
      sig = {sample_req, audio_lrck, audio_sck, audio_mclk};
      for (int k = 0; k < 4; k++) begin
        if (sig[k]) hi_cnt[k]++;
        if (sig[k] && !psig[k]) begin
          rise_cnt[k]++;
          if (last_rise[k] >= 0 && i - last_rise[k] != period[k]) bad_int[k]++;
          last_rise[k] = i;
        end
      end
      psig = sig;
    end
    for (int k = 0; k < 4; k++) begin
      chk({names[k], "_high_cycles"}, 64'(hi_cnt[k]), 64'(exp_hi[k]));
      chk({names[k], "_rises"}, 64'(rise_cnt[k]), 64'(exp_rise[k]));
      chk({names[k], "_period"}, 64'(bad_int[k]), 64'd0);
    end

    // Frame data: directed, random, mid-frame change, and silence.
    new_l[0] = 16'hA5C3; new_r[0] = 16'h5000;
    for (int k = 1; k < 9; k++) begin
      new_l[k] = 16'($urandom);
      new_r[k] = 16'($urandom);
      mid_at[k] = -1;
    end
    mid_at[0] = -1;
    new_l[5] = 16'hB000;
    new_l[6] = 16'hB000;
    mid_at[6] = 8;
    new_l[7] = 16'h0000; new_r[7] = 16'h0000;
    held_l = audio_left;
    held_r = audio_right;
    for (int k = 0; k < 9; k++) begin
      exp_frame = i2s_frame(held_l, held_r);
      audio_left = new_l[k];
      audio_right = new_r[k];
      collect_until_req(2100, mid_at[k], 16'h1000, ncyc, bits, nrise);
      chk($sformatf("frame%0d_length", k), 64'(ncyc), 64'd2048);
      chk($sformatf("frame%0d_sck_rises", k), 64'(nrise), 64'd64);
      chk($sformatf("frame%0d_left_word", k), 64'(bits[62:47]), 64'(held_l));
      chk($sformatf("frame%0d_right_word", k), 64'(bits[30:15]), 64'(held_r));
      chk($sformatf("frame%0d_bits", k), bits, exp_frame);
      held_l = audio_left;
      held_r = audio_right;
    end

    // Asynchronous reset in the middle of a frame.
    audio_left = 16'hFFFF;
    audio_right = 16'hFFFF;
    collect_until_req(2100, -1, '0, ncyc, bits, nrise);
    chk("pre_reset_frame", bits, i2s_frame(held_l, held_r));
    repeat (1100) step();
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", 64'(outs()), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_held_outputs", 64'(outs()), 64'd0);
    rst = 1'b0;
    collect_until_req(2100, -1, '0, ncyc, bits, nrise);
    chk("midrun_reset_first_req", 64'(ncyc), 64'd2048);
    chk("midrun_reset_zero_frame", bits, 64'd0);

    // Drop enable at slot 40, then re-enable: holds survive.
    held_l = 16'hFFFF;
    held_r = 16'hFFFF;
    audio_left = 16'($urandom);
    audio_right = 16'($urandom);
    collect_until_req(2100, -1, '0, ncyc, bits, nrise);
    chk("ffff_frame", bits, i2s_frame(held_l, held_r));
    held_l = audio_left;
    held_r = audio_right;
    nrise = 0;
    ps = audio_sck;
    for (int i = 0; i < 2100 && nrise < 41; i++) begin
      step();
      if (audio_sck && !ps) nrise++;
      ps = audio_sck;
    end
    chk("reached_slot40", 64'(nrise), 64'd41);
    chk("lrck_high_at_slot40", 64'(audio_lrck), 64'd1);
    enable = 1'b0;
    audio_left = ~held_l;
    audio_right = ~held_r;
    step();
    chk("disable_next_cycle", 64'(outs()), 64'd0);
    acc = '0;
    repeat (60) begin
      step();
      acc = acc | outs();
    end
    chk("disable_stays_quiet", 64'(acc), 64'd0);
    enable = 1'b1;
    collect_until_req(2100, -1, '0, ncyc, bits, nrise);
    chk("reenable_first_req", 64'(ncyc), 64'd2048);
    chk("reenable_frame_held", bits, i2s_frame(held_l, held_r));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
